// File: rtl/seq_sum_pkg.sv
// rtl/seq_sum_pkg.sv - shared state type and counter sizing for seq_sum
package seq_sum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Beat counter width; COUNT >= 2 so at least one bit is always needed.
    function automatic int cnt_width(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/add_carry.sv
// rtl/add_carry.sv - WIDTH-bit unsigned adder with carry out
module add_carry #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/seq_sum.sv
// rtl/seq_sum.sv - sums COUNT operands per result; SEQ_SUM_SAT_EN selects saturating accumulation
module seq_sum
    import seq_sum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf
);

    localparam int            CW   = cnt_width(COUNT);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             ovf;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] acc_next;

    add_carry #(.WIDTH(WIDTH)) u_add (
        .a  (acc),
        .b  (in_data),
        .s  (sum),
        .co (carry)
    );

    always_comb begin
        acc_next = sum;
`ifdef SEQ_SUM_SAT_EN
        // Once any carry has been seen, the result stays pinned at all ones.
        if (ovf || carry) begin
            acc_next = '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (clear) begin
                        acc <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end else if (in_valid) begin
                        acc <= acc_next;
                        ovf <= ovf | carry;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= HOLD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    // clear is deliberately ignored here so a finished result is never dropped.
                    if (out_ready) begin
                        state <= ACCUM;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign out_sum   = acc;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_seq_sum.sv
// tb/tb_seq_sum.sv - scoreboard bench for seq_sum (WIDTH=8, COUNT=4)
module tb_seq_sum;

    typedef struct {
        logic [7:0] sum;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_ovf;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    seq_sum #(.WIDTH(8), .COUNT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic push(input logic [7:0] s, input logic o);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    // Monitor: a result is consumed on any edge where out_valid && out_ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_sum", int'(out_sum), int'(e.sum));
                chk("out_ovf", int'(out_ovf), int'(e.ovf));
            end
        end
    end

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("send_timeout", 1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_in_ready"},  int'(in_ready), 1);
        chk({tag, "_out_sum"},   int'(out_sum), 0);
        chk({tag, "_out_ovf"},   int'(out_ovf), 0);
    endtask

    initial begin
        logic [7:0] ops[8];
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        idle(2);
        chk_reset("por");
        rst = 1'b0;

        // Basic sum and one-cycle latency, then handoff back to ACCUM
        push(8'd10, 1'b0);
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        chk("latency_out_valid", int'(out_valid), 1);
        chk("hold_in_ready", int'(in_ready), 0);
        idle(1);
        chk("handoff_in_ready", int'(in_ready), 1);
        drain();

        // Overflow
`ifdef SEQ_SUM_SAT_EN
        push(8'd255, 1'b1);
`else
        push(8'd44, 1'b1);
`endif
        send(8'd200); send(8'd100); send(8'd0); send(8'd0);
        drain();

        // Backpressure: held result stable, no operand consumed
        out_ready = 1'b0;
        push(8'd15, 1'b0);
        send(8'd1); send(8'd2); send(8'd4); send(8'd8);
        in_valid = 1'b1;
        in_data  = 8'd99;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_sum", int'(out_sum), 15);
            idle(1);
        end
        out_ready = 1'b1;
        idle(1);
        push(8'd12, 1'b0);
        send(8'd3); send(8'd3); send(8'd3); send(8'd3);
        drain();

        // Clear mid-sum discards the presented operand
        send(8'd5); send(8'd6);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd7;
        idle(1);
        clear    = 1'b0;
        in_valid = 1'b0;
        push(8'd4, 1'b0);
        send(8'd1); send(8'd1); send(8'd1); send(8'd1);
        drain();

        // Clear ignored in HOLD
        out_ready = 1'b0;
        push(8'd8, 1'b0);
        send(8'd2); send(8'd2); send(8'd2); send(8'd2);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        chk("clr_hold_valid", int'(out_valid), 1);
        chk("clr_hold_sum", int'(out_sum), 8);
        out_ready = 1'b1;
        drain();

        // Reset mid-sum and in HOLD
        send(8'd9); send(8'd9);
        rst = 1'b1;
        idle(1);
        chk_reset("rst_mid");
        rst = 1'b0;
        out_ready = 1'b0;
        send(8'd7); send(8'd7); send(8'd7); send(8'd7);
        chk("pre_rst_hold", int'(out_valid), 1);
        rst = 1'b1;
        idle(1);
        chk_reset("rst_hold");
        rst = 1'b0;
        out_ready = 1'b1;
        push(8'd4, 1'b0);
        send(8'd1); send(8'd1); send(8'd1); send(8'd1);
        drain();

        // Gapped traffic: 10+20+30+40=100; 50+60+70+80=260 -> wraps to 4
        ops[0] = 8'd10; ops[1] = 8'd20; ops[2] = 8'd30; ops[3] = 8'd40;
        ops[4] = 8'd50; ops[5] = 8'd60; ops[6] = 8'd70; ops[7] = 8'd80;
        push(8'd100, 1'b0);
`ifdef SEQ_SUM_SAT_EN
        push(8'd255, 1'b1);
`else
        push(8'd4, 1'b1);
`endif
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, 3));
            send(ops[i]);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_sum.md
SEQ_SUM -- requirements
Module: seq_sum

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (>=1).
REQ-002 SHALL have parameter COUNT, default 4, operands summed per result (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port clear  input  1  synchronous abort of the partial sum in progress.
REQ-006 SHALL have port in_valid  input  1  in_data holds an operand.
REQ-007 SHALL have port in_ready  output  1  block accepts an operand this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  operand, unsigned.
REQ-009 SHALL have port out_valid  output  1  out_sum and out_ovf hold a completed result.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port out_sum  output  WIDTH  sum of COUNT operands.
REQ-012 SHALL have port out_ovf  output  1  at least one carry out of bit WIDTH-1 occurred during this result.

Function
REQ-013 SHALL implement FSM states ACCUM and HOLD.
REQ-014 ACCUM: in_ready=1 and out_valid=0; an operand is accepted when in_valid&&in_ready.
REQ-015 Each accepted operand SHALL update acc <= acc + in_data (WIDTH-bit add) and increment beat counter cnt (width $clog2(COUNT)).
REQ-016 Any carry out of the add SHALL set sticky ovf.
REQ-017 On the accepted beat with cnt==COUNT-1, the FSM SHALL enter HOLD next cycle, with out_sum = final sum including that beat (latency 1 cycle from last accept).
REQ-018 HOLD: in_ready=0, out_valid=1; out_sum and out_ovf SHALL remain stable until out_ready.
REQ-019 HOLD with out_ready=1: next cycle SHALL be ACCUM with acc=0, cnt=0, ovf=0; no back-to-back accept in the handoff cycle.
REQ-020 clear=1 in ACCUM SHALL zero acc, cnt, ovf next cycle and discard any operand presented that cycle (clear beats in_valid).
REQ-021 clear SHALL be ignored in HOLD; the held result is never lost.
REQ-022 in_valid with in_ready=0 SHALL have no effect; in_data not sampled.

Reset
REQ-023 rst=1 SHALL force next cycle: state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, in_ready=1, out_sum=0, out_ovf=0.
REQ-024 rst SHALL override clear, in_valid and out_ready, including mid-sum and in HOLD.

Configuration
REQ-025 Macro SEQ_SUM_SAT_EN defined: once ovf is set, acc SHALL clamp to all ones and stay clamped for the rest of that result.
REQ-026 SEQ_SUM_SAT_EN undefined: acc SHALL wrap modulo 2^WIDTH; out_ovf still reported.

Structure
REQ-027 Package seq_sum_pkg SHALL hold the state enum type and the function computing the cnt width from COUNT.
REQ-028 The WIDTH-bit adder with carry-out SHALL be a sub-module add_carry (inputs a, b; outputs s, co).

Verification (WIDTH=8, COUNT=4)
REQ-029 Operands 1,2,3,4 back-to-back, out_ready=1 -> out_valid one cycle after 4th accept, out_sum=10, out_ovf=0, then ACCUM.
REQ-030 Operands 200,100,0,0 -> out_ovf=1; out_sum=44 without SEQ_SUM_SAT_EN, 255 with it.
REQ-031 Result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_sum constant, no operand consumed; release -> next sum starts at 0.
REQ-032 Operands 5,6 accepted, then clear with in_valid=1 and data 7, then 1,1,1,1 -> out_sum=4.
REQ-033 rst asserted after 2 accepts and again during HOLD -> all outputs match REQ-023 next cycle; subsequent 1,1,1,1 -> out_sum=4.
REQ-034 in_valid toggled randomly with gaps -> out_sum equals reference sum of exactly 4 accepted operands per result.
